// File: rtl/branch_predict_resolve_if.sv
// Decode-side branch interface between the fetch/ID stage and the branch
// predictor/resolver.
//   master : ID stage. It drives id_valid/id_pc/id_instr and the operands, and
//            it consumes the prediction and resolution outputs.
//   slave  : branch_predict_resolve.
// Optional statistics outputs are present only when BRANCH_STATS_EN is defined.
interface branch_predict_resolve_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        is_branch;
  logic        predict_taken;
  logic        compflg;
  logic        actual_taken;
  logic [31:0] calculated_target_pc;
  logic        mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output id_valid, id_pc, id_instr, rs1_data, rs2_data,
    input  is_branch, predict_taken, compflg, actual_taken,
           calculated_target_pc, mispredict, stat_branches, stat_mispredicts
  );
  modport slave (
    input  id_valid, id_pc, id_instr, rs1_data, rs2_data,
    output is_branch, predict_taken, compflg, actual_taken,
           calculated_target_pc, mispredict, stat_branches, stat_mispredicts
  );
`else
  modport master (
    output id_valid, id_pc, id_instr, rs1_data, rs2_data,
    input  is_branch, predict_taken, compflg, actual_taken,
           calculated_target_pc, mispredict
  );
  modport slave (
    input  id_valid, id_pc, id_instr, rs1_data, rs2_data,
    output is_branch, predict_taken, compflg, actual_taken,
           calculated_target_pc, mispredict
  );
`endif
endinterface

// File: rtl/branch_predict_resolve.sv
// Branch predictor / resolver on the decode side.
// In ID it decodes conditional branches (32-bit B-type and compressed CB).
// It predicts from a table of 2-bit saturating counters indexed by the
// halfword PC. In the following cycle it resolves the outcome and the target,
// then trains the counter.
// Ports:
//   clk, reset  : clock; synchronous active-high reset
//   bus (slave) : id_valid/id_pc/id_instr/rs1_data/rs2_data in;
//                 is_branch/predict_taken/compflg (Mealy in IDLE),
//                 actual_taken/calculated_target_pc/mispredict (RESOLVE only) out
// Optional feature macro: BRANCH_STATS_EN. When it is defined, the block adds
// the saturating stat_branches and stat_mispredicts counters on the bus.
module branch_predict_resolve #(
  parameter int BHT_ENTRIES = 64
) (
  input  logic clk,
  input  logic reset,
  branch_predict_resolve_if.slave bus
);
  localparam int IW = $clog2(BHT_ENTRIES);

  typedef enum logic {IDLE, RESOLVE} state_t;

  // Branch context captured in IDLE and consumed in RESOLVE. For compressed
  // branches f3 holds the CB funct3, and only bit 0 matters (beqz/bnez).
  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   imm;
    logic [2:0]    f3;
    logic          comp;
    logic          pred;
    logic [IW-1:0] idx;
  } br_lat_t;

  state_t     state;
  br_lat_t    lat;
  logic [1:0] bht [BHT_ENTRIES];

  // ---------------- decode ----------------
  logic [31:0]   ins;
  logic          comp;
  logic [2:0]    f3_32, f3_16;
  logic          br32, br16;
  logic [31:0]   imm_b, imm_cb;
  logic [IW-1:0] id_idx;

  assign ins    = bus.id_instr;
  assign comp   = ins[1:0] != 2'b11;
  assign f3_32  = ins[14:12];
  assign f3_16  = ins[15:13];
  // funct3 010/011 are not branches.
  assign br32   = !comp && ins[6:0] == 7'b1100011 && f3_32[2:1] != 2'b01;
  assign br16   = ins[1:0] == 2'b01 && f3_16[2:1] == 2'b11;
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_cb = {{23{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10],
                   ins[4:3], 1'b0};
  assign id_idx = bus.id_pc[IW:1];

  // The register-number fields are not needed, because operands arrive on rs*_data.
  logic unused_bits;
  assign unused_bits = ^ins[24:16];

  logic id_br;
  assign id_br = (state == IDLE) && bus.id_valid && (br32 || br16);

  // ---------------- resolve ----------------
  logic taken;
  always_comb begin
    taken = 1'b0;
    if (lat.comp) begin
      taken = lat.f3[0] ? (bus.rs1_data != 32'd0) : (bus.rs1_data == 32'd0);
    end else begin
      case (lat.f3)
        3'b000:  taken = bus.rs1_data == bus.rs2_data;
        3'b001:  taken = bus.rs1_data != bus.rs2_data;
        3'b100:  taken = $signed(bus.rs1_data) <  $signed(bus.rs2_data);
        3'b101:  taken = $signed(bus.rs1_data) >= $signed(bus.rs2_data);
        3'b110:  taken = bus.rs1_data <  bus.rs2_data;
        3'b111:  taken = bus.rs1_data >= bus.rs2_data;
        default: taken = 1'b0;
      endcase
    end
  end

  logic resolving;
  assign resolving = state == RESOLVE;

  // Saturating counter step for the latched index.
  logic [1:0] ctr_cur, ctr_nxt;
  assign ctr_cur = bht[lat.idx];
  always_comb begin
    ctr_nxt = ctr_cur;
    if (taken && ctr_cur != 2'b11)        ctr_nxt = ctr_cur + 2'b01;
    else if (!taken && ctr_cur != 2'b00)  ctr_nxt = ctr_cur - 2'b01;
  end

  // ---------------- outputs ----------------
  // Lookup is masked in RESOLVE, so the read of bht here never races
  // the update of the same entry.
  assign bus.is_branch            = id_br;
  assign bus.predict_taken        = id_br && bht[id_idx][1];
  assign bus.compflg              = resolving ? lat.comp : comp;
  assign bus.actual_taken         = resolving && taken;
  assign bus.calculated_target_pc = resolving ? lat.pc + lat.imm : 32'd0;
  assign bus.mispredict           = resolving && (taken != lat.pred);

  // ---------------- FSM + table ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lat   <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else begin
      case (state)
        IDLE: begin
          if (id_br) begin
            lat.pc   <= bus.id_pc;
            lat.imm  <= comp ? imm_cb : imm_b;
            lat.f3   <= comp ? f3_16 : f3_32;
            lat.comp <= comp;
            lat.pred <= bht[id_idx][1];
            lat.idx  <= id_idx;
            state    <= RESOLVE;
          end
        end
        RESOLVE: begin
          bht[lat.idx] <= ctr_nxt;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] st_br, st_mp;
  always_ff @(posedge clk) begin
    if (reset) begin
      st_br <= '0;
      st_mp <= '0;
    end else begin
      if (resolving && st_br != 32'hFFFF_FFFF) st_br <= st_br + 32'd1;
      if (bus.mispredict && st_mp != 32'hFFFF_FFFF) st_mp <= st_mp + 32'd1;
    end
  end
  assign bus.stat_branches    = st_br;
  assign bus.stat_mispredicts = st_mp;
`endif
endmodule

// File: tb/tb_branch_predict_resolve.sv
module tb_branch_predict_resolve;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_predict_resolve_if bus();
  branch_predict_resolve #(.BHT_ENTRIES(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: one integer counter per entry, plus expected statistics.
  int cnt [64];
  int st_br, st_mp;

  // Context of the branch currently awaiting resolution.
  logic [31:0] p_pc, p_imm;
  logic        p_comp, p_pred;
  logic [2:0]  p_f3;
  int          p_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_cb(input logic bnez, input logic [31:0] imm);
    return {16'h0000, 2'b11, bnez, imm[8], imm[4:3], 3'd1, imm[7:6], imm[2:1],
            imm[5], 2'b01};
  endfunction

  function automatic logic exp_taken(input logic comp, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
    if (comp) return f3[0] ? (a != 0) : (a == 0);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) cnt[i] = 1;
    st_br = 0;
    st_mp = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a branch in IDLE and check the Mealy outputs.
  task automatic present(input logic [31:0] pc, input logic comp, input logic [2:0] f3,
                         input logic [31:0] imm);
    bus.id_valid = 1'b1;
    bus.id_pc    = pc;
    bus.id_instr = comp ? enc_cb(f3[0], imm) : enc_b(f3, imm);
    p_pc = pc; p_imm = imm; p_comp = comp; p_f3 = f3;
    p_idx  = int'(pc[6:1]);
    p_pred = cnt[p_idx] >= 2;
    #4;
    chk("is_branch", bus.is_branch, 1);
    chk("predict_taken", bus.predict_taken, p_pred);
    chk("compflg_id", bus.compflg, comp);
    chk("idle_actual", bus.actual_taken, 0);
  endtask

  // Drive operands in RESOLVE, check the outputs, and train the model.
  task automatic resolve(input logic [31:0] a, input logic [31:0] b);
    logic t;
    bus.rs1_data = a;
    bus.rs2_data = b;
    t = exp_taken(p_comp, p_f3, a, b);
    #4;
    chk("resolve_is_branch", bus.is_branch, 0);
    chk("resolve_pred_masked", bus.predict_taken, 0);
    chk("actual_taken", bus.actual_taken, t);
    chk("target_pc", bus.calculated_target_pc, p_pc + p_imm);
    chk("mispredict", bus.mispredict, t != p_pred);
    chk("compflg_res", bus.compflg, p_comp);
    cnt[p_idx] = t ? (cnt[p_idx] < 3 ? cnt[p_idx] + 1 : 3)
                   : (cnt[p_idx] > 0 ? cnt[p_idx] - 1 : 0);
    st_br++;
    if (t != p_pred) st_mp++;
  endtask

  task automatic run_br(input logic [31:0] pc, input logic comp, input logic [2:0] f3,
                        input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
    present(pc, comp, f3, imm);
    step();
    bus.id_valid = 1'($urandom_range(0, 1));  // wrong-path content in ID
    resolve(a, b);
    step();
    bus.id_valid = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3s [6];
    logic [31:0] pcs [8];
    logic [31:0] r, a, b, imm;
    logic        c;
    logic [2:0]  f;
    f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    pcs = '{32'h1000, 32'h1004, 32'h100A, 32'h2002, 32'h2010, 32'h3FFE, 32'h4040, 32'h5086};

    bus.id_valid = 1'b0;
    bus.id_pc    = 32'h0;
    bus.id_instr = 32'h13;
    bus.rs1_data = 32'h0;
    bus.rs2_data = 32'h0;
    model_reset();
    step(); step();
    reset = 1'b0;
    #4;
    chk("rst_is_branch", bus.is_branch, 0);
    chk("rst_predict", bus.predict_taken, 0);
    chk("rst_compflg", bus.compflg, 0);
    chk("rst_actual", bus.actual_taken, 0);
    chk("rst_target", bus.calculated_target_pc, 0);
    chk("rst_mispredict", bus.mispredict, 0);
    step();

    // beq at 0x100, imm +16, taken three times, then not-taken.
    run_br(32'h100, 1'b0, 3'd0, 32'd16, 32'd5, 32'd5);
    run_br(32'h100, 1'b0, 3'd0, 32'd16, 32'd5, 32'd5);
    run_br(32'h100, 1'b0, 3'd0, 32'd16, 32'd5, 32'd5);
    run_br(32'h100, 1'b0, 3'd0, 32'd16, 32'd5, 32'd6);
    run_br(32'h100, 1'b0, 3'd0, 32'd16, 32'd5, 32'd6);

    // c.bnez at 0x202, imm -4, rs1 = 0.
    run_br(32'h202, 1'b1, 3'd7, 32'hFFFF_FFFC, 32'd0, 32'h1234);

    // blt vs bltu with -1 vs 1.
    run_br(32'h400, 1'b0, 3'd4, 32'd64, 32'hFFFF_FFFF, 32'd1);
    run_br(32'h404, 1'b0, 3'd6, 32'd64, 32'hFFFF_FFFF, 32'd1);

    // Target wraps modulo 2^32.
    run_br(32'hFFFF_FFF0, 1'b0, 3'd1, 32'd32, 32'd1, 32'd2);

    // Non-branches: funct3 010, a compressed non-CB op, and an invalid slot.
    bus.id_valid = 1'b1; bus.id_pc = 32'h500; bus.id_instr = enc_b(3'd2, 32'd8);
    #4; chk("nonbranch_f3_010", bus.is_branch, 0);
    step(); bus.id_instr = {16'h0, 16'hA001};
    #4; chk("nonbranch_c_j", bus.is_branch, 0);
    step(); bus.id_valid = 1'b0; bus.id_instr = enc_b(3'd0, 32'd8);
    #4; chk("invalid_branch", bus.is_branch, 0);
    chk("no_resolve", bus.actual_taken, 0);
    step();

    // Back-to-back: B is in ID during A's RESOLVE, then re-presented in IDLE.
    present(32'h600, 1'b0, 3'd0, 32'd12);
    step();
    bus.id_valid = 1'b1; bus.id_pc = 32'h640; bus.id_instr = enc_b(3'd1, 32'd20);
    resolve(32'd7, 32'd7);
    step();
    present(32'h640, 1'b0, 3'd1, 32'd20);
    step();
    resolve(32'd7, 32'd8);
    step();
    bus.id_valid = 1'b0;

    // Reset asserted in RESOLVE drops the update; the counter reads 01 afterwards.
    present(32'h3C0, 1'b0, 3'd0, 32'd8);
    step();
    bus.id_valid = 1'b0;
    bus.rs1_data = 32'd3; bus.rs2_data = 32'd3;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    #4;
    chk("rst_res_actual", bus.actual_taken, 0);
    chk("rst_res_target", bus.calculated_target_pc, 0);
    chk("rst_res_mispredict", bus.mispredict, 0);
    step();
    present(32'h3C0, 1'b0, 3'd0, 32'd8);
    chk("rst_res_counter", bus.predict_taken, 0);
    step();
    resolve(32'd3, 32'd3);
    step();
    bus.id_valid = 1'b0;

    // Randomized branches over a small PC set so that counters train and saturate.
    for (int n = 0; n < 60; n++) begin
      c = 1'($urandom_range(0, 3) == 0);
      f = c ? {2'b11, 1'($urandom_range(0, 1))} : f3s[$urandom_range(0, 5)];
      r = $urandom;
      imm = c ? {{23{r[8]}}, r[8:1], 1'b0} : {{19{r[12]}}, r[12:1], 1'b0};
      a = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
      case ($urandom_range(0, 2))
        0: b = a;
        1: b = $urandom;
        default: b = a ^ 32'h8000_0000;
      endcase
      run_br(pcs[$urandom_range(0, 7)], c, f, imm, a, b);
    end

`ifdef BRANCH_STATS_EN
    chk("stat_branches", bus.stat_branches, st_br);
    chk("stat_mispredicts", bus.stat_mispredicts, st_mp);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
